// File: rtl/register_file.sv
// register_file: architectural register file with rename tags for the Tomasulo core.
// Each register holds a committed value, a busy flag and the ROB tag of its newest
// in-flight producer. Operand reads are fully combinational and return either a
// ready value or the ROB tag the operand waits on.
// Optional feature: define RF_CMT_BYPASS_EN to forward a same-cycle commit of the
// producing ROB entry straight into the operand read.
module register_file #(
    parameter int REG_BW = 5,
    parameter int ROB_BW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              inst_ID_flag,
    input  logic [REG_BW-1:0] inst_ID_des,
    input  logic [ROB_BW-1:0] ROB_ava_id,
    input  logic [REG_BW-1:0] ID_rs1,
    input  logic [REG_BW-1:0] ID_rs2,
    output logic              ID_rs1_ready,
    output logic [31:0]       ID_rs1_val,
    output logic [ROB_BW-1:0] ID_rs1_tag,
    output logic              ID_rs2_ready,
    output logic [31:0]       ID_rs2_val,
    output logic [ROB_BW-1:0] ID_rs2_tag,
    output logic [ROB_BW-1:0] RF_id1,
    output logic [ROB_BW-1:0] RF_id2,
    input  logic              RF_id1_ready,
    input  logic [31:0]       RF_id1_val,
    input  logic              RF_id2_ready,
    input  logic [31:0]       RF_id2_val,
    input  logic              ROB_cmt_rf_flag,
    input  logic [REG_BW-1:0] ROB_cmt_rf_des,
    input  logic [ROB_BW-1:0] ROB_cmt_rf_rob_id,
    input  logic [31:0]       ROB_cmt_rf_val
);

    localparam int unsigned NREG = 1 << REG_BW;

    typedef struct packed {
        logic              ready;
        logic [31:0]       val;
        logic [ROB_BW-1:0] tag;
        logic [ROB_BW-1:0] qid;
    } rd_t;

    logic [31:0]       val_q  [NREG];
    logic [ROB_BW-1:0] tag_q  [NREG];
    logic              busy_q [NREG];

    logic ren_en;
    logic cmt_en;
    rd_t  rd1;
    rd_t  rd2;

    assign ren_en = rdy && !jump_wrong && inst_ID_flag    && (inst_ID_des    != '0);
    assign cmt_en = rdy && !jump_wrong && ROB_cmt_rf_flag && (ROB_cmt_rf_des != '0);

    // Resolve one operand from pre-edge state plus the ROB forwarding answer.
    function automatic rd_t read_port(input logic [REG_BW-1:0] rs,
                                      input logic              q_ready,
                                      input logic [31:0]       q_val);
        rd_t r;
        r.ready = 1'b1;
        r.val   = '0;
        r.tag   = '0;
        r.qid   = '0;
        if (rs != '0) begin
            if (!busy_q[rs]) begin
                r.val = val_q[rs];
            end else begin
                r.qid = tag_q[rs];
`ifdef RF_CMT_BYPASS_EN
                if (ROB_cmt_rf_flag && ROB_cmt_rf_des == rs && ROB_cmt_rf_rob_id == tag_q[rs]) begin
                    r.val = ROB_cmt_rf_val;
                end else
`endif
                if (q_ready) begin
                    r.val = q_val;
                end else begin
                    r.ready = 1'b0;
                    r.tag   = tag_q[rs];
                end
            end
        end
        return r;
    endfunction

    // Combinational operand lookup for both ID source ports.
    always_comb begin
        rd1 = read_port(ID_rs1, RF_id1_ready, RF_id1_val);
        rd2 = read_port(ID_rs2, RF_id2_ready, RF_id2_val);
    end

    assign ID_rs1_ready = rd1.ready;
    assign ID_rs1_val   = rd1.val;
    assign ID_rs1_tag   = rd1.tag;
    assign RF_id1       = rd1.qid;
    assign ID_rs2_ready = rd2.ready;
    assign ID_rs2_val   = rd2.val;
    assign ID_rs2_tag   = rd2.tag;
    assign RF_id2       = rd2.qid;

    // State update: reset, then flush, else commit followed by rename (rename wins on busy/tag).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                val_q[i]  <= '0;
                tag_q[i]  <= '0;
                busy_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (jump_wrong) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    busy_q[i] <= 1'b0;
                end
            end else begin
                if (cmt_en) begin
                    val_q[ROB_cmt_rf_des] <= ROB_cmt_rf_val;
                    if (tag_q[ROB_cmt_rf_des] == ROB_cmt_rf_rob_id &&
                        !(ren_en && inst_ID_des == ROB_cmt_rf_des)) begin
                        busy_q[ROB_cmt_rf_des] <= 1'b0;
                    end
                end
                if (ren_en) begin
                    busy_q[inst_ID_des] <= 1'b1;
                    tag_q[inst_ID_des]  <= ROB_ava_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic checked against a
// behavioural register-file model held in plain arrays.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong, inst_ID_flag;
    logic [4:0]  inst_ID_des, ID_rs1, ID_rs2, ROB_cmt_rf_des;
    logic [3:0]  ROB_ava_id, ROB_cmt_rf_rob_id;
    logic        ID_rs1_ready, ID_rs2_ready;
    logic [31:0] ID_rs1_val, ID_rs2_val;
    logic [3:0]  ID_rs1_tag, ID_rs2_tag, RF_id1, RF_id2;
    logic        RF_id1_ready, RF_id2_ready, ROB_cmt_rf_flag;
    logic [31:0] RF_id1_val, RF_id2_val, ROB_cmt_rf_val;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0] m_val  [32];
    logic [3:0]  m_tag  [32];
    logic        m_busy [32];

    register_file #(.REG_BW(5), .ROB_BW(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .inst_ID_flag(inst_ID_flag), .inst_ID_des(inst_ID_des), .ROB_ava_id(ROB_ava_id),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_ready(ID_rs1_ready), .ID_rs1_val(ID_rs1_val), .ID_rs1_tag(ID_rs1_tag),
        .ID_rs2_ready(ID_rs2_ready), .ID_rs2_val(ID_rs2_val), .ID_rs2_tag(ID_rs2_tag),
        .RF_id1(RF_id1), .RF_id2(RF_id2),
        .RF_id1_ready(RF_id1_ready), .RF_id1_val(RF_id1_val),
        .RF_id2_ready(RF_id2_ready), .RF_id2_val(RF_id2_val),
        .ROB_cmt_rf_flag(ROB_cmt_rf_flag), .ROB_cmt_rf_des(ROB_cmt_rf_des),
        .ROB_cmt_rf_rob_id(ROB_cmt_rf_rob_id), .ROB_cmt_rf_val(ROB_cmt_rf_val)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0;
        inst_ID_flag = 1'b0; inst_ID_des = '0; ROB_ava_id = '0;
        ID_rs1 = '0; ID_rs2 = '0;
        RF_id1_ready = 1'b0; RF_id1_val = '0; RF_id2_ready = 1'b0; RF_id2_val = '0;
        ROB_cmt_rf_flag = 1'b0; ROB_cmt_rf_des = '0; ROB_cmt_rf_rob_id = '0; ROB_cmt_rf_val = '0;
    endtask

    // Apply the register-file rules to the model using the inputs present at the edge.
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
            end
        end else if (rdy && jump_wrong) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (rdy) begin
            if (ROB_cmt_rf_flag && ROB_cmt_rf_des != 0) begin
                m_val[ROB_cmt_rf_des] = ROB_cmt_rf_val;
                if (m_tag[ROB_cmt_rf_des] == ROB_cmt_rf_rob_id &&
                    !(inst_ID_flag && inst_ID_des == ROB_cmt_rf_des))
                    m_busy[ROB_cmt_rf_des] = 1'b0;
            end
            if (inst_ID_flag && inst_ID_des != 0) begin
                m_busy[inst_ID_des] = 1'b1;
                m_tag[inst_ID_des]  = ROB_ava_id;
            end
        end
    endtask

    // One clock: model follows the edge, then return at the negedge for new stimulus.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Expected read result from model state and the current inputs.
    function automatic void exp_read(input logic [4:0] rs, input logic qr, input logic [31:0] qv,
                                     output logic e_rdy, output logic [31:0] e_val,
                                     output logic [3:0] e_tag, output logic [3:0] e_qid);
        e_rdy = 1'b1; e_val = 32'd0; e_tag = 4'd0; e_qid = 4'd0;
        if (rs == 0) return;
        if (!m_busy[rs]) begin
            e_val = m_val[rs];
            return;
        end
        e_qid = m_tag[rs];
`ifdef RF_CMT_BYPASS_EN
        if (ROB_cmt_rf_flag && ROB_cmt_rf_des == rs && ROB_cmt_rf_rob_id == m_tag[rs]) begin
            e_val = ROB_cmt_rf_val;
            return;
        end
`endif
        if (qr) e_val = qv;
        else begin
            e_rdy = 1'b0;
            e_tag = m_tag[rs];
        end
    endfunction

    task automatic test_reset();
        idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
        ID_rs1 = 5'd5; #1;
        total++; if (ID_rs1_ready !== 1'b1 || ID_rs1_val !== 32'd0 || ID_rs1_tag !== 4'd0 || RF_id1 !== 4'd0) begin
            bad++; $display("FAIL reset_read: got rdy=%b val=%h tag=%h id=%h, want 1/0/0/0", ID_rs1_ready, ID_rs1_val, ID_rs1_tag, RF_id1);
        end
    endtask

    task automatic test_rename_forward();
        idle(); inst_ID_flag = 1'b1; inst_ID_des = 5'd5; ROB_ava_id = 4'd3; tick(); idle();
        ID_rs1 = 5'd5; #1;
        total++; if (RF_id1 !== 4'd3 || ID_rs1_ready !== 1'b0 || ID_rs1_tag !== 4'd3) begin
            bad++; $display("FAIL rename_wait: got id=%h rdy=%b tag=%h, want 3/0/3", RF_id1, ID_rs1_ready, ID_rs1_tag);
        end
        RF_id1_ready = 1'b1; RF_id1_val = 32'h1234; #1;
        total++; if (ID_rs1_ready !== 1'b1 || ID_rs1_val !== 32'h1234 || ID_rs1_tag !== 4'd0) begin
            bad++; $display("FAIL rob_forward: got rdy=%b val=%h tag=%h, want 1/1234/0", ID_rs1_ready, ID_rs1_val, ID_rs1_tag);
        end
    endtask

    task automatic test_commit();
        idle(); ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_des = 5'd5; ROB_cmt_rf_rob_id = 4'd3; ROB_cmt_rf_val = 32'hAB;
        tick(); idle(); ID_rs1 = 5'd5; #1;
        total++; if (ID_rs1_ready !== 1'b1 || ID_rs1_val !== 32'hAB || RF_id1 !== 4'd0) begin
            bad++; $display("FAIL commit_clear: got rdy=%b val=%h id=%h, want 1/ab/0", ID_rs1_ready, ID_rs1_val, RF_id1);
        end
    endtask

    task automatic test_stale_commit();
        idle(); inst_ID_flag = 1'b1; inst_ID_des = 5'd5; ROB_ava_id = 4'd4; tick(); idle();
        ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_des = 5'd5; ROB_cmt_rf_rob_id = 4'd3; ROB_cmt_rf_val = 32'h11;
        tick(); idle(); ID_rs1 = 5'd5; #1;
        total++; if (ID_rs1_ready !== 1'b0 || ID_rs1_tag !== 4'd4 || RF_id1 !== 4'd4) begin
            bad++; $display("FAIL stale_commit: got rdy=%b tag=%h id=%h, want 0/4/4", ID_rs1_ready, ID_rs1_tag, RF_id1);
        end
        inst_ID_flag = 1'b1; inst_ID_des = 5'd6; ROB_ava_id = 4'd2; tick(); idle();
        inst_ID_flag = 1'b1; inst_ID_des = 5'd6; ROB_ava_id = 4'd7;
        ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_des = 5'd6; ROB_cmt_rf_rob_id = 4'd2; ROB_cmt_rf_val = 32'h66;
        tick(); idle(); ID_rs2 = 5'd6; #1;
        total++; if (ID_rs2_ready !== 1'b0 || ID_rs2_tag !== 4'd7 || RF_id2 !== 4'd7) begin
            bad++; $display("FAIL rename_wins: got rdy=%b tag=%h id=%h, want 0/7/7", ID_rs2_ready, ID_rs2_tag, RF_id2);
        end
    endtask

    task automatic test_flush_and_freeze();
        idle(); inst_ID_flag = 1'b1; inst_ID_des = 5'd7; ROB_ava_id = 4'd9; tick();
        jump_wrong = 1'b1; inst_ID_des = 5'd8; ROB_ava_id = 4'd5; tick(); tick(); idle();
        ID_rs1 = 5'd5; ID_rs2 = 5'd6; #1;
        total++; if (ID_rs1_ready !== 1'b1 || ID_rs1_val !== 32'h11 || ID_rs2_ready !== 1'b1 || ID_rs2_val !== 32'h66) begin
            bad++; $display("FAIL flush_vals: got x5 %b/%h x6 %b/%h, want 1/11 1/66", ID_rs1_ready, ID_rs1_val, ID_rs2_ready, ID_rs2_val);
        end
        ID_rs1 = 5'd7; ID_rs2 = 5'd8; #1;
        total++; if (ID_rs1_ready !== 1'b1 || ID_rs1_val !== 32'd0 || ID_rs2_ready !== 1'b1 || RF_id2 !== 4'd0) begin
            bad++; $display("FAIL flush_busy: got x7 %b/%h x8 %b id=%h, want 1/0 1 0", ID_rs1_ready, ID_rs1_val, ID_rs2_ready, RF_id2);
        end
        rdy = 1'b0; inst_ID_flag = 1'b1; inst_ID_des = 5'd8; ROB_ava_id = 4'd1;
        ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_des = 5'd7; ROB_cmt_rf_rob_id = 4'd0; ROB_cmt_rf_val = 32'h77;
        tick(); tick(); idle(); ID_rs1 = 5'd7; ID_rs2 = 5'd8; #1;
        total++; if (ID_rs1_val !== 32'd0 || ID_rs2_ready !== 1'b1 || RF_id2 !== 4'd0) begin
            bad++; $display("FAIL rdy_freeze: got x7 val=%h x8 rdy=%b id=%h, want 0 1 0", ID_rs1_val, ID_rs2_ready, RF_id2);
        end
    endtask

    task automatic test_commit_bypass();
        idle(); inst_ID_flag = 1'b1; inst_ID_des = 5'd9; ROB_ava_id = 4'd2; tick(); idle();
        ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_des = 5'd9; ROB_cmt_rf_rob_id = 4'd2; ROB_cmt_rf_val = 32'h55;
        ID_rs2 = 5'd9; #1;
`ifdef RF_CMT_BYPASS_EN
        total++; if (ID_rs2_ready !== 1'b1 || ID_rs2_val !== 32'h55) begin
            bad++; $display("FAIL cmt_bypass: got rdy=%b val=%h, want 1/55", ID_rs2_ready, ID_rs2_val);
        end
`else
        total++; if (ID_rs2_ready !== 1'b0 || ID_rs2_tag !== 4'd2) begin
            bad++; $display("FAIL cmt_nobypass: got rdy=%b tag=%h, want 0/2", ID_rs2_ready, ID_rs2_tag);
        end
`endif
        tick(); idle(); ID_rs2 = 5'd9; #1;
        total++; if (ID_rs2_ready !== 1'b1 || ID_rs2_val !== 32'h55) begin
            bad++; $display("FAIL cmt_next: got rdy=%b val=%h, want 1/55", ID_rs2_ready, ID_rs2_val);
        end
    endtask

    task automatic test_x0();
        idle(); inst_ID_flag = 1'b1; inst_ID_des = 5'd0; ROB_ava_id = 4'd6;
        ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_des = 5'd0; ROB_cmt_rf_rob_id = 4'd0; ROB_cmt_rf_val = 32'hFF;
        tick(); idle(); ID_rs1 = 5'd0; #1;
        total++; if (ID_rs1_ready !== 1'b1 || ID_rs1_val !== 32'd0 || RF_id1 !== 4'd0) begin
            bad++; $display("FAIL x0_read: got rdy=%b val=%h id=%h, want 1/0/0", ID_rs1_ready, ID_rs1_val, RF_id1);
        end
    endtask

    task automatic test_random();
        logic e_rdy; logic [31:0] e_val; logic [3:0] e_tag, e_qid;
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            rdy          = ($urandom_range(0, 9) != 0);
            jump_wrong   = ($urandom_range(0, 14) == 0);
            inst_ID_flag = $urandom_range(0, 1);
            inst_ID_des  = 5'($urandom_range(0, 7));
            ROB_ava_id   = 4'($urandom);
            ROB_cmt_rf_flag = $urandom_range(0, 1);
            ROB_cmt_rf_des  = 5'($urandom_range(0, 7));
            ROB_cmt_rf_rob_id = $urandom_range(0, 1) ? m_tag[ROB_cmt_rf_des] : 4'($urandom);
            ROB_cmt_rf_val  = $urandom;
            ID_rs1 = 5'($urandom_range(0, 7));
            ID_rs2 = 5'($urandom_range(0, 7));
            RF_id1_ready = $urandom_range(0, 1); RF_id1_val = $urandom;
            RF_id2_ready = $urandom_range(0, 1); RF_id2_val = $urandom;
            #1;
            exp_read(ID_rs1, RF_id1_ready, RF_id1_val, e_rdy, e_val, e_tag, e_qid);
            total++; if (ID_rs1_ready !== e_rdy || ID_rs1_val !== e_val || ID_rs1_tag !== e_tag || RF_id1 !== e_qid) begin
                bad++; $display("FAIL rand_rs1 n=%0d rs=%0d: got %b/%h/%h/%h, want %b/%h/%h/%h", n, ID_rs1,
                                ID_rs1_ready, ID_rs1_val, ID_rs1_tag, RF_id1, e_rdy, e_val, e_tag, e_qid);
            end
            exp_read(ID_rs2, RF_id2_ready, RF_id2_val, e_rdy, e_val, e_tag, e_qid);
            total++; if (ID_rs2_ready !== e_rdy || ID_rs2_val !== e_val || ID_rs2_tag !== e_tag || RF_id2 !== e_qid) begin
                bad++; $display("FAIL rand_rs2 n=%0d rs=%0d: got %b/%h/%h/%h, want %b/%h/%h/%h", n, ID_rs2,
                                ID_rs2_ready, ID_rs2_val, ID_rs2_tag, RF_id2, e_rdy, e_val, e_tag, e_qid);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_rename_forward();
        test_commit();
        test_stale_commit();
        test_flush_and_freeze();
        test_commit_bypass();
        test_x0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
